// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcodes,
// ALU operation codes, instruction classes and trap causes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_RTYPE = 4'd2;
  localparam logic [3:0] ALU_BR    = 4'd7;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_LD   = 3'd2,
    CL_ADDI = 3'd3,
    CL_ST   = 3'd4,
    CL_BR   = 3'd5
  } class_e;

  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_TIMEOUT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_op_class.sv
// Combinational opcode-to-class decoder; anything outside the supported
// RV32 subset is flagged illegal and reported as CL_NONE.
module op_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output class_e     class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o   = CL_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_R:    class_o = CL_R;
      OP_LD:   class_o = CL_LD;
      OP_ADDI: class_o = CL_ADDI;
      OP_ST:   class_o = CL_ST;
      OP_BR:   class_o = CL_BR;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps a shared ALU and one handshaked memory
// port through FETCH/DECODE/EXEC/MEM/WB, with sticky trap and retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wrt,
  output logic             ir_wrt,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_wrt,
  output logic             mem_rd,
  output logic             mem_wrt,
  output logic             br,
  output logic [3:0]       alu_op,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [7:0]       wait_q, wait_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             timeout;
  class_e           dec_class;
  logic             dec_illegal;

  op_class u_op_class (
    .opcode_i  (opcode),
    .class_o   (dec_class),
    .illegal_o (dec_illegal)
  );

  assign timeout = (wait_q == WAIT_LIM);

  // The wait counter defaults to zero, so it clears on every entry to FETCH/MEM
  // and only counts while an access is stalled in place.
  always_comb begin
    state_d    = state_q;
    class_d    = class_q;
    wait_d     = '0;
    trap_d     = trap_q;
    cause_d    = cause_q;
    instret_d  = instret_q;
    retire     = 1'b0;
    pc_wrt     = 1'b0;
    ir_wrt     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wrt    = 1'b0;
    mem_rd     = 1'b0;
    mem_wrt    = 1'b0;
    br         = 1'b0;
    alu_op     = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wrt  = 1'b1;
          pc_wrt  = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        class_d = dec_class;
        if (dec_illegal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          CL_R: begin
            alu_op  = ALU_RTYPE;
            state_d = S_WB;
          end
          CL_ADDI: begin
            alu_src = 1'b1;
            state_d = S_WB;
          end
          CL_LD, CL_ST: begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          CL_BR: begin
            alu_op = ALU_BR;
            br     = 1'b1;
            pc_wrt = zero;
            retire = 1'b1;
          end
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = TC_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        if (class_q == CL_ST) mem_wrt = 1'b1;
        else                  mem_rd  = 1'b1;
        if (mem_ready) begin
          if (class_q == CL_ST) retire  = 1'b1;
          else                  state_d = S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = TC_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_wrt    = 1'b1;
        mem_to_reg = (class_q == CL_LD);
        retire     = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
      state_d   = en ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= CL_NONE;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= TC_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign state      = state_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-cycle vector table for a mixed program
// plus hand sequences for trap, timeout and mid-access reset.
module tb_multicycle_ctrl;

  localparam int OPR    = 'b0110011;
  localparam int OPLD   = 'b0000011;
  localparam int OPADDI = 'b0010011;
  localparam int OPST   = 'b0100011;
  localparam int OPBR   = 'b1100011;
  localparam int OPBAD  = 'b1111111;

  // Strobe bundle order: pc_wrt, ir_wrt, alu_src, mem_to_reg, reg_wrt, mem_rd, mem_wrt, br
  localparam int SB_NONE  = 'b0000_0000;
  localparam int SB_FWAIT = 'b0000_0100;
  localparam int SB_FOK   = 'b1100_0100;
  localparam int SB_ALUI  = 'b0010_0000;
  localparam int SB_BRT   = 'b1000_0001;
  localparam int SB_BRN   = 'b0000_0001;
  localparam int SB_MLD   = 'b0010_0100;
  localparam int SB_MST   = 'b0010_0010;
  localparam int SB_WBR   = 'b0000_1000;
  localparam int SB_WBL   = 'b0001_1000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_wrt, ir_wrt, alu_src, mem_to_reg, reg_wrt, mem_rd, mem_wrt, br;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  typedef struct {
    logic        en;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [2:0]  st;
    logic [7:0]  sb;
    logic [3:0]  aop;
    logic        trp;
    logic [1:0]  cause;
    logic [31:0] ir;
  } vec_t;

  vec_t sbQ[$];
  vec_t tbl[28];
  int   nCompared = 0;
  int   nMismatched = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_wrt     (pc_wrt),
    .ir_wrt     (ir_wrt),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_wrt    (reg_wrt),
    .mem_rd     (mem_rd),
    .mem_wrt    (mem_wrt),
    .br         (br),
    .alu_op     (alu_op),
    .state      (state),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int e, input int op, input int z, input int r,
                              input int st, input int sb, input int aop,
                              input int trp, input int cause, input int ir);
    vec_t v;
    v.en    = e[0];
    v.op    = op[6:0];
    v.z     = z[0];
    v.rdy   = r[0];
    v.st    = st[2:0];
    v.sb    = sb[7:0];
    v.aop   = aop[3:0];
    v.trp   = trp[0];
    v.cause = cause[1:0];
    v.ir    = ir;
    return v;
  endfunction

  task automatic checkOutput(input string name);
    vec_t       x;
    logic [7:0] sbAct;
    x = sbQ.pop_front();
    sbAct = {pc_wrt, ir_wrt, alu_src, mem_to_reg, reg_wrt, mem_rd, mem_wrt, br};
    nCompared++;
    if (state !== x.st || sbAct !== x.sb || alu_op !== x.aop || trap !== x.trp ||
        trap_cause !== x.cause || instret !== x.ir) begin
      nMismatched++;
      $display("[TB] FAIL %s: got st=%0d strb=%b aop=%0d trap=%b cause=%0d instret=%0d, want st=%0d strb=%b aop=%0d trap=%b cause=%0d instret=%0d",
               name, state, sbAct, alu_op, trap, trap_cause, instret,
               x.st, x.sb, x.aop, x.trp, x.cause, x.ir);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk);
    en        = v.en;
    opcode    = v.op;
    zero      = v.z;
    mem_ready = v.rdy;
    sbQ.push_back(v);
    #1 checkOutput(name);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    en        = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    sbQ.push_back(mk(0, 0, 0, 0, 0, SB_NONE, 0, 0, 0, 0));
    #1 checkOutput("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;

    // R, LD (2 wait states), ST, BR taken, BR not taken, ADDI with en dropped
    tbl[0]  = mk(1, OPR,    0, 1, 0, SB_NONE, 0, 0, 0, 0);
    tbl[1]  = mk(1, OPR,    0, 1, 1, SB_FOK,  0, 0, 0, 0);
    tbl[2]  = mk(1, OPR,    0, 1, 2, SB_NONE, 0, 0, 0, 0);
    tbl[3]  = mk(1, OPR,    0, 1, 3, SB_NONE, 2, 0, 0, 0);
    tbl[4]  = mk(1, OPR,    0, 1, 5, SB_WBR,  0, 0, 0, 0);
    tbl[5]  = mk(1, OPLD,   0, 1, 1, SB_FOK,  0, 0, 0, 1);
    tbl[6]  = mk(1, OPLD,   0, 0, 2, SB_NONE, 0, 0, 0, 1);
    tbl[7]  = mk(1, OPLD,   0, 0, 3, SB_ALUI, 0, 0, 0, 1);
    tbl[8]  = mk(1, OPLD,   0, 0, 4, SB_MLD,  0, 0, 0, 1);
    tbl[9]  = mk(1, OPLD,   0, 0, 4, SB_MLD,  0, 0, 0, 1);
    tbl[10] = mk(1, OPLD,   0, 1, 4, SB_MLD,  0, 0, 0, 1);
    tbl[11] = mk(1, OPLD,   0, 0, 5, SB_WBL,  0, 0, 0, 1);
    tbl[12] = mk(1, OPST,   0, 1, 1, SB_FOK,  0, 0, 0, 2);
    tbl[13] = mk(1, OPST,   0, 1, 2, SB_NONE, 0, 0, 0, 2);
    tbl[14] = mk(1, OPST,   0, 1, 3, SB_ALUI, 0, 0, 0, 2);
    tbl[15] = mk(1, OPST,   0, 1, 4, SB_MST,  0, 0, 0, 2);
    tbl[16] = mk(1, OPBR,   0, 1, 1, SB_FOK,  0, 0, 0, 3);
    tbl[17] = mk(1, OPBR,   1, 1, 2, SB_NONE, 0, 0, 0, 3);
    tbl[18] = mk(1, OPBR,   1, 1, 3, SB_BRT,  7, 0, 0, 3);
    tbl[19] = mk(1, OPBR,   0, 1, 1, SB_FOK,  0, 0, 0, 4);
    tbl[20] = mk(1, OPBR,   0, 1, 2, SB_NONE, 0, 0, 0, 4);
    tbl[21] = mk(1, OPBR,   0, 1, 3, SB_BRN,  7, 0, 0, 4);
    tbl[22] = mk(1, OPADDI, 0, 1, 1, SB_FOK,  0, 0, 0, 5);
    tbl[23] = mk(1, OPADDI, 0, 1, 2, SB_NONE, 0, 0, 0, 5);
    tbl[24] = mk(1, OPADDI, 0, 1, 3, SB_ALUI, 0, 0, 0, 5);
    tbl[25] = mk(0, OPADDI, 0, 1, 5, SB_WBR,  0, 0, 0, 5);
    tbl[26] = mk(0, OPADDI, 0, 1, 0, SB_NONE, 0, 0, 0, 6);
    tbl[27] = mk(0, OPADDI, 0, 1, 0, SB_NONE, 0, 0, 0, 6);

    doReset();
    for (int i = 0; i < 28; i++) applyStimulus(tbl[i], $sformatf("prog_vec%0d", i));

    // Illegal opcode: sticky trap regardless of en
    doReset();
    applyStimulus(mk(1, OPBAD, 0, 1, 0, SB_NONE, 0, 0, 0, 0), "ill_idle");
    applyStimulus(mk(1, OPBAD, 0, 1, 1, SB_FOK,  0, 0, 0, 0), "ill_fetch");
    applyStimulus(mk(1, OPBAD, 0, 1, 2, SB_NONE, 0, 0, 0, 0), "ill_decode");
    for (int i = 0; i < 10; i++)
      applyStimulus(mk(i % 2, OPBAD, 0, (i % 3 == 0) ? 1 : 0, 7, SB_NONE, 0, 1, 1, 0),
                    $sformatf("ill_trap%0d", i));

    // Fetch timeout: 16 stalled FETCH cycles then trap
    doReset();
    applyStimulus(mk(1, OPR, 0, 0, 0, SB_NONE, 0, 0, 0, 0), "to_idle");
    for (int k = 0; k < 16; k++)
      applyStimulus(mk(1, OPR, 0, 0, 1, SB_FWAIT, 0, 0, 0, 0), $sformatf("to_fetch%0d", k));
    applyStimulus(mk(1, OPR, 0, 1, 7, SB_NONE, 0, 1, 2, 0), "to_trap0");
    applyStimulus(mk(0, OPR, 0, 1, 7, SB_NONE, 0, 1, 2, 0), "to_trap1");

    // Ready arriving on the limit cycle completes normally
    doReset();
    applyStimulus(mk(1, OPR, 0, 0, 0, SB_NONE, 0, 0, 0, 0), "lim_idle");
    for (int k = 0; k < 16; k++)
      applyStimulus(mk(1, OPR, 0, (k == 15) ? 1 : 0, 1, (k == 15) ? SB_FOK : SB_FWAIT, 0, 0, 0, 0),
                    $sformatf("lim_fetch%0d", k));
    applyStimulus(mk(1, OPR, 0, 1, 2, SB_NONE, 0, 0, 0, 0), "lim_decode");
    applyStimulus(mk(1, OPR, 0, 1, 3, SB_NONE, 2, 0, 0, 0), "lim_exec");
    applyStimulus(mk(1, OPR, 0, 1, 5, SB_WBR,  0, 0, 0, 0), "lim_wb");
    applyStimulus(mk(1, OPR, 0, 1, 1, SB_FOK,  0, 0, 0, 1), "lim_next");

    // Reset in the middle of a stalled store
    doReset();
    applyStimulus(mk(1, OPADDI, 0, 1, 0, SB_NONE, 0, 0, 0, 0), "rs_idle");
    applyStimulus(mk(1, OPADDI, 0, 1, 1, SB_FOK,  0, 0, 0, 0), "rs_f0");
    applyStimulus(mk(1, OPADDI, 0, 1, 2, SB_NONE, 0, 0, 0, 0), "rs_d0");
    applyStimulus(mk(1, OPADDI, 0, 1, 3, SB_ALUI, 0, 0, 0, 0), "rs_e0");
    applyStimulus(mk(1, OPADDI, 0, 1, 5, SB_WBR,  0, 0, 0, 0), "rs_w0");
    applyStimulus(mk(1, OPST,   0, 1, 1, SB_FOK,  0, 0, 0, 1), "rs_f1");
    applyStimulus(mk(1, OPST,   0, 1, 2, SB_NONE, 0, 0, 0, 1), "rs_d1");
    applyStimulus(mk(1, OPST,   0, 1, 3, SB_ALUI, 0, 0, 0, 1), "rs_e1");
    applyStimulus(mk(1, OPST,   0, 0, 4, SB_MST,  0, 0, 0, 1), "rs_mem");
    #1 rst_n = 1'b0;
    #1;
    sbQ.push_back(mk(1, OPST, 0, 0, 0, SB_NONE, 0, 0, 0, 0));
    checkOutput("rs_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(mk(1, OPR, 0, 1, 0, SB_NONE, 0, 0, 0, 0), "rs_resume_idle");
    applyStimulus(mk(1, OPR, 0, 1, 1, SB_FOK,  0, 0, 0, 0), "rs_resume_f");
    applyStimulus(mk(1, OPR, 0, 1, 2, SB_NONE, 0, 0, 0, 0), "rs_resume_d");
    applyStimulus(mk(1, OPR, 0, 1, 3, SB_NONE, 2, 0, 0, 0), "rs_resume_e");
    applyStimulus(mk(1, OPR, 0, 1, 5, SB_WBR,  0, 0, 0, 0), "rs_resume_w");
    applyStimulus(mk(1, OPR, 0, 1, 1, SB_FOK,  0, 0, 0, 1), "rs_resume_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
